// File: rtl/alu1_issue_queue.sv
// Issue stage in front of the combinational Alu1 block: an in-order request FIFO
// whose head drives the ALU, plus a registered valid/ready slot that holds the result.
module alu1_issue_queue #(
  parameter int unsigned WIDTH     = 64,
  parameter int unsigned CMD_WIDTH = 4,
  parameter int unsigned DEPTH     = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [CMD_WIDTH-1:0]         in_cmd,
  input  logic [WIDTH-1:0]             in_op1,
  input  logic [WIDTH-1:0]             in_op2,
  output logic [CMD_WIDTH-1:0]         alu_cmd,
  output logic [WIDTH-1:0]             alu_in1,
  output logic [WIDTH-1:0]             alu_in2,
  input  logic [WIDTH-1:0]             alu_out,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [WIDTH-1:0]             res_data,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  typedef struct packed {
    logic [CMD_WIDTH-1:0] cmd;
    logic [WIDTH-1:0]     op1;
    logic [WIDTH-1:0]     op2;
  } entry_t;

  entry_t           mem [DEPTH];
  entry_t           head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push;
  logic             pop;
  logic             slot_free;

  // Handshake decode; a full FIFO refuses even when it pops this cycle.
  always_comb begin
    in_ready  = (count != CNT_W'(DEPTH));
    push      = in_valid && in_ready;
    slot_free = !res_valid || res_ready;
    pop       = (count != '0) && slot_free;
    head      = '0;
    if (count != '0) begin
      head = mem[rd_ptr];
    end
  end

  assign alu_cmd = head.cmd;
  assign alu_in1 = head.op1;
  assign alu_in2 = head.op2;

  // Entry storage is deliberately left uninitialised; occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= '{cmd: in_cmd, op1: in_op1, op2: in_op2};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      res_valid <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr    <= rd_ptr + PTR_W'(1);
        res_data  <= alu_out;
        res_valid <= 1'b1;
      end else if (res_valid && res_ready) begin
        res_valid <= 1'b0;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_alu1_issue_queue.sv
// Bench for alu1_issue_queue: directed vector table, hand-written corner sequences
// and random traffic, all compared against a queue-based reference model.
module tb_alu1_issue_queue;

  localparam int W    = 64;
  localparam int CW   = 4;
  localparam int D    = 4;
  localparam int CNTW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] in_cmd;
  logic [W-1:0]  in_op1;
  logic [W-1:0]  in_op2;
  logic [CW-1:0] alu_cmd;
  logic [W-1:0]  alu_in1;
  logic [W-1:0]  alu_in2;
  logic [W-1:0]  alu_out;
  logic          res_valid;
  logic          res_ready;
  logic [W-1:0]  res_data;
  logic [CNTW-1:0] count;

  alu1_issue_queue #(.WIDTH(W), .CMD_WIDTH(CW), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_cmd(in_cmd), .in_op1(in_op1), .in_op2(in_op2),
    .alu_cmd(alu_cmd), .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_out(alu_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .count(count)
  );

  always #5 clk = ~clk;

  // Stand-in for Alu1.
  assign alu_out = alu_in1 ^ alu_in2;

  typedef struct {
    logic [CW-1:0] cmd;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
  } req_t;

  typedef struct {
    logic         iv;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         rr;
    logic         e_rv;
    logic [W-1:0] e_rd;
    int           e_cnt;
    logic         e_rdy;
  } vec_t;

  req_t         mq[$];
  logic         m_rv;
  logic [W-1:0] m_rd;
  vec_t         tv[$];
  int           n_chk  = 0;
  int           n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%h expected 0x%h at %0t", nm, act, exp, $time);
  endtask

  function automatic void model_reset();
    mq.delete();
    m_rv = 1'b0;
    m_rd = '0;
  endfunction

  // One clock edge of the reference: results come out of a queue in arrival order.
  function automatic void model_edge(input logic iv, input logic [CW-1:0] c,
                                     input logic [W-1:0] a, input logic [W-1:0] b,
                                     input logic rr, input logic fl);
    req_t r;
    bit   rdy;
    rdy = (mq.size() != D);
    if (fl) begin
      mq.delete();
      m_rv = 1'b0;
      return;
    end
    if (mq.size() != 0 && (!m_rv || rr)) begin
      r    = mq.pop_front();
      m_rd = r.a ^ r.b;
      m_rv = 1'b1;
    end else if (m_rv && rr) begin
      m_rv = 1'b0;
    end
    if (iv && rdy) begin
      r.cmd = c; r.a = a; r.b = b;
      mq.push_back(r);
    end
  endfunction

  task automatic model_check();
    logic [CW-1:0] hc;
    logic [W-1:0]  ha;
    logic [W-1:0]  hb;
    hc = '0; ha = '0; hb = '0;
    if (mq.size() != 0) begin
      hc = mq[0].cmd; ha = mq[0].a; hb = mq[0].b;
    end
    chk("m_count",     64'(count),     64'(mq.size()));
    chk("m_in_ready",  64'(in_ready),  64'(mq.size() != D));
    chk("m_alu_cmd",   64'(alu_cmd),   64'(hc));
    chk("m_alu_in1",   alu_in1,        ha);
    chk("m_alu_in2",   alu_in2,        hb);
    chk("m_res_valid", 64'(res_valid), 64'(m_rv));
    chk("m_res_data",  res_data,       m_rd);
  endtask

  task automatic cycle(input logic iv, input logic [CW-1:0] c, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic rr, input logic fl);
    in_valid = iv; in_cmd = c; in_op1 = a; in_op2 = b; res_ready = rr; flush = fl;
    #1;
    model_check();
    @(posedge clk);
    model_edge(iv, c, a, b, rr, fl);
    #1;
  endtask

  function automatic void mkv(input logic iv, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic rr, input logic e_rv, input logic [W-1:0] e_rd,
                              input int e_cnt, input logic e_rdy);
    vec_t v;
    v.iv = iv; v.a = a; v.b = b; v.rr = rr;
    v.e_rv = e_rv; v.e_rd = e_rd; v.e_cnt = e_cnt; v.e_rdy = e_rdy;
    tv.push_back(v);
  endfunction

  initial begin
    // Expected state after each edge: single op latency, fill to full, then streaming.
    mkv(1, 64'h0F, 64'hF0, 1,  0, 64'h00, 1, 1);
    mkv(0, 64'h00, 64'h00, 1,  1, 64'hFF, 0, 1);
    mkv(0, 64'h00, 64'h00, 1,  0, 64'hFF, 0, 1);
    mkv(1, 64'h11, 64'h01, 0,  0, 64'hFF, 1, 1);
    mkv(1, 64'h12, 64'h01, 0,  1, 64'h10, 1, 1);
    mkv(1, 64'h13, 64'h01, 0,  1, 64'h10, 2, 1);
    mkv(1, 64'h14, 64'h01, 0,  1, 64'h10, 3, 1);
    mkv(1, 64'h15, 64'h01, 0,  1, 64'h10, 4, 0);
    mkv(1, 64'h16, 64'h01, 0,  1, 64'h10, 4, 0);
    mkv(1, 64'h17, 64'h01, 1,  1, 64'h13, 3, 1);
    mkv(1, 64'h18, 64'h01, 1,  1, 64'h12, 3, 1);
    mkv(1, 64'h1A, 64'h01, 1,  1, 64'h15, 3, 1);
    mkv(1, 64'h1C, 64'h01, 1,  1, 64'h14, 3, 1);
    mkv(1, 64'h1E, 64'h01, 1,  1, 64'h19, 3, 1);
    mkv(0, 64'h00, 64'h00, 1,  1, 64'h1B, 2, 1);
    mkv(0, 64'h00, 64'h00, 1,  1, 64'h1D, 1, 1);
    mkv(0, 64'h00, 64'h00, 1,  1, 64'h1F, 0, 1);
    mkv(0, 64'h00, 64'h00, 1,  0, 64'h1F, 0, 1);

    rst_n = 1'b0; flush = 0; in_valid = 0; in_cmd = '0; in_op1 = '0; in_op2 = '0; res_ready = 0;
    model_reset();
    #12;
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_count",     64'(count),     64'd0);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_res_data",  res_data,       64'd0);
    chk("rst_alu_cmd",   64'(alu_cmd),   64'd0);
    chk("rst_alu_in1",   alu_in1,        64'd0);
    chk("rst_alu_in2",   alu_in2,        64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (tv[i]) begin
      cycle(tv[i].iv, CW'(i), tv[i].a, tv[i].b, tv[i].rr, 1'b0);
      chk($sformatf("tv%0d_res_valid", i), 64'(res_valid), 64'(tv[i].e_rv));
      chk($sformatf("tv%0d_res_data", i),  res_data,       tv[i].e_rd);
      chk($sformatf("tv%0d_count", i),     64'(count),     64'(tv[i].e_cnt));
      chk($sformatf("tv%0d_in_ready", i),  64'(in_ready),  64'(tv[i].e_rdy));
    end

    // Stalled result slot holds 0xAA while the queue keeps filling.
    cycle(1, 4'h3, 64'hAA, 64'h00, 0, 0);
    cycle(0, 4'h0, 64'h00, 64'h00, 0, 0);
    for (int k = 0; k < 5; k++) begin
      cycle(1, CW'(k), {$urandom, $urandom}, {$urandom, $urandom}, 0, 0);
      chk("hold_res_data",  res_data,       64'hAA);
      chk("hold_res_valid", 64'(res_valid), 64'd1);
      chk("hold_count",     64'(count),     64'((k < 4) ? k + 1 : 4));
    end
    for (int k = 0; k < 6; k++) cycle(0, 4'h0, 64'h0, 64'h0, 1, 0);

    // Flush with a request offered in the same cycle.
    for (int k = 0; k < 4; k++) cycle(1, CW'(k + 5), 64'(k + 64'h40), 64'h3, 0, 0);
    chk("pre_flush_count", 64'(count), 64'd3);
    cycle(1, 4'h9, 64'h55, 64'h0, 0, 1);
    chk("flush_count",     64'(count),     64'd0);
    chk("flush_res_valid", 64'(res_valid), 64'd0);
    chk("flush_alu_cmd",   64'(alu_cmd),   64'd0);
    chk("flush_alu_in1",   alu_in1,        64'd0);
    chk("flush_alu_in2",   alu_in2,        64'd0);
    for (int k = 0; k < 3; k++) begin
      cycle(0, 4'h0, 64'h0, 64'h0, 1, 0);
      chk("post_flush_res_valid", 64'(res_valid), 64'd0);
    end

    // Asynchronous reset between clock edges with two ops queued.
    for (int k = 0; k < 3; k++) cycle(1, CW'(k), 64'(k + 64'h70), 64'h5, 0, 0);
    chk("pre_rst_count", 64'(count), 64'd2);
    #2;
    in_valid = 0; res_ready = 0; flush = 0;
    rst_n = 1'b0;
    #1;
    chk("arst_res_valid", 64'(res_valid), 64'd0);
    chk("arst_count",     64'(count),     64'd0);
    chk("arst_alu_in1",   alu_in1,        64'd0);
    chk("arst_alu_in2",   alu_in2,        64'd0);
    chk("arst_alu_cmd",   64'(alu_cmd),   64'd0);
    chk("arst_in_ready",  64'(in_ready),  64'd1);
    chk("arst_res_data",  res_data,       64'd0);
    model_reset();
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Random traffic with alternating back-pressure phases and rare flushes.
    for (int i = 0; i < 600; i++) begin
      logic rr;
      rr = ((i / 50) % 2 == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      cycle($urandom_range(0, 3) != 0, CW'($urandom), {$urandom, $urandom},
            {$urandom, $urandom}, rr, $urandom_range(0, 40) == 0);
    end
    for (int k = 0; k < 6; k++) cycle(0, 4'h0, 64'h0, 64'h0, 1, 0);
    model_check();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
